mc_control_seq: RTL and testbench

- Multicycle control unit for the ARM-subset processor: main state machine, instruction decode, ALU decode, NZCV flag register and conditional write gating.
- Sequences the multicycle datapath (PC, IR, register file, ALU, memory muxes).
- Receives CondEx from the condition-check block and drives Flags back to it.
- Sits beside the datapath in the top-level processor.

---
 rtl/mc_control_seq_if.sv | 34 +++
 rtl/mc_control_seq.sv | 156 +++++++++++++++
 tb/tb_mc_control_seq.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mc_control_seq_if.sv
// Control-unit to datapath bundle: instruction/flag inputs and control outputs.
// master = control unit, slave = datapath and condition checker.
interface mc_control_seq_if #(
   parameter int STATE_W = 4
);
   logic [31:0]        Instr;
   logic [3:0]         ALUFlags;
   logic               CondEx;
   logic [3:0]         Flags;
   logic               PCWrite;
   logic               MemWrite;
   logic               RegWrite;
   logic               IRWrite;
   logic               AdrSrc;
   logic [1:0]         ALUSrcA;
   logic [1:0]         ALUSrcB;
   logic [1:0]         ResultSrc;
   logic [1:0]         ImmSrc;
   logic [1:0]         RegSrc;
   logic [1:0]         ALUControl;
   logic [STATE_W-1:0] State;

   modport master (
      input  Instr, ALUFlags, CondEx,
      output Flags, PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc,
             ALUSrcA, ALUSrcB, ResultSrc, ImmSrc, RegSrc, ALUControl, State
   );

   modport slave (
      output Instr, ALUFlags, CondEx,
      input  Flags, PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc,
             ALUSrcA, ALUSrcB, ResultSrc, ImmSrc, RegSrc, ALUControl, State
   );
endinterface

// File: rtl/mc_control_seq.sv
// Multicycle control unit: main FSM, instruction/ALU decode, NZCV register and
// condition-gated write enables. Only state, flags and the latched CondEx are registered.
module mc_control_seq #(
   parameter int STATE_W = 4
) (
   input  logic                 clk,
   input  logic                 reset,
   mc_control_seq_if.master     bus
);
   typedef enum logic [STATE_W-1:0] {
      S_FETCH  = STATE_W'(0),
      S_DECODE = STATE_W'(1),
      S_MEMADR = STATE_W'(2),
      S_MEMRD  = STATE_W'(3),
      S_MEMWB  = STATE_W'(4),
      S_MEMWR  = STATE_W'(5),
      S_EXECR  = STATE_W'(6),
      S_EXECI  = STATE_W'(7),
      S_ALUWB  = STATE_W'(8),
      S_BRANCH = STATE_W'(9)
   } state_t;

   state_t      r_state;
   state_t      w_next;
   logic [3:0]  r_flags;
   logic        r_condex;

   logic [1:0]  w_op;
   logic [5:0]  w_funct;
   logic [3:0]  w_rd;
   logic [1:0]  w_alu_ctl;
   logic        w_alu_valid;
   logic        w_alu_addsub;
   logic        w_alu_op;
   logic [1:0]  w_flag_w;

   logic        w_next_pc;
   logic        w_branch;
   logic        w_reg_w;
   logic        w_mem_w;
   logic        w_ir_write;
   logic        w_adr_src;
   logic [1:0]  w_src_a;
   logic [1:0]  w_src_b;
   logic [1:0]  w_result_src;
   logic        w_pcs;

   assign w_op    = bus.Instr[27:26];
   assign w_funct = bus.Instr[25:20];
   assign w_rd    = bus.Instr[15:12];

   always_comb begin
      w_next = S_FETCH;
      case (r_state)
         S_FETCH:  w_next = S_DECODE;
         S_DECODE: begin
            case (w_op)
               2'b00:   w_next = w_funct[5] ? S_EXECI : S_EXECR;
               2'b01:   w_next = S_MEMADR;
               2'b10:   w_next = S_BRANCH;
               default: w_next = S_FETCH;
            endcase
         end
         S_MEMADR: w_next = w_funct[0] ? S_MEMRD : S_MEMWR;
         S_MEMRD:  w_next = S_MEMWB;
         S_EXECR,
         S_EXECI:  w_next = S_ALUWB;
         default:  w_next = S_FETCH;
      endcase
   end

   // Unsupported data-processing commands decode as ADD but are marked invalid,
   // which suppresses both the register write-back and any flag update.
   always_comb begin
      w_alu_ctl    = 2'b00;
      w_alu_valid  = 1'b1;
      w_alu_addsub = 1'b0;
      case (w_funct[4:1])
         4'b0100: begin w_alu_ctl = 2'b00; w_alu_addsub = 1'b1; end
         4'b0010: begin w_alu_ctl = 2'b01; w_alu_addsub = 1'b1; end
         4'b0000: w_alu_ctl = 2'b10;
         4'b1100: w_alu_ctl = 2'b11;
         default: w_alu_valid = 1'b0;
      endcase
   end

   assign w_alu_op    = (r_state == S_EXECR) || (r_state == S_EXECI);
   assign w_flag_w[1] = w_alu_op & w_alu_valid & w_funct[0];
   assign w_flag_w[0] = w_flag_w[1] & w_alu_addsub;

   always_comb begin
      w_next_pc    = 1'b0;
      w_branch     = 1'b0;
      w_reg_w      = 1'b0;
      w_mem_w      = 1'b0;
      w_ir_write   = 1'b0;
      w_adr_src    = 1'b0;
      w_src_a      = 2'b00;
      w_src_b      = 2'b00;
      w_result_src = 2'b00;
      case (r_state)
         S_FETCH: begin
            w_src_a = 2'b01; w_src_b = 2'b10; w_result_src = 2'b10;
            w_ir_write = 1'b1; w_next_pc = 1'b1;
         end
         S_DECODE: begin
            w_src_a = 2'b01; w_src_b = 2'b10; w_result_src = 2'b10;
         end
         S_MEMADR: w_src_b = 2'b01;
         S_MEMRD:  w_adr_src = 1'b1;
         S_MEMWB:  begin w_result_src = 2'b01; w_reg_w = 1'b1; end
         S_MEMWR:  begin w_adr_src = 1'b1; w_mem_w = 1'b1; end
         S_EXECR:  w_src_b = 2'b00;
         S_EXECI:  w_src_b = 2'b01;
         S_ALUWB:  w_reg_w = w_alu_valid;
         S_BRANCH: begin
            w_src_b = 2'b01; w_result_src = 2'b10; w_branch = 1'b1;
         end
         default: ;
      endcase
   end

   assign w_pcs = ((w_rd == 4'hF) & w_reg_w) | w_branch;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state  <= S_FETCH;
         r_flags  <= 4'b0000;
         r_condex <= 1'b0;
      end else begin
         r_state <= w_next;
         if (r_state == S_DECODE)
            r_condex <= bus.CondEx;
         if (r_condex) begin
            if (w_flag_w[1])
               r_flags[3:2] <= bus.ALUFlags[3:2];
            if (w_flag_w[0])
               r_flags[1:0] <= bus.ALUFlags[1:0];
         end
      end
   end

   assign bus.Flags      = r_flags;
   assign bus.PCWrite    = w_next_pc | (w_pcs & r_condex);
   assign bus.RegWrite   = w_reg_w & r_condex;
   assign bus.MemWrite   = w_mem_w & r_condex;
   assign bus.IRWrite    = w_ir_write;
   assign bus.AdrSrc     = w_adr_src;
   assign bus.ALUSrcA    = w_src_a;
   assign bus.ALUSrcB    = w_src_b;
   assign bus.ResultSrc  = w_result_src;
   assign bus.ImmSrc     = w_op;
   assign bus.RegSrc     = {w_op == 2'b01, w_op == 2'b10};
   assign bus.ALUControl = w_alu_op ? w_alu_ctl : 2'b00;
   assign bus.State      = r_state;
endmodule

// File: tb/tb_mc_control_seq.sv
// Bench for mc_control_seq: directed instructions plus random ones, checked
// cycle by cycle against an instruction-level model of states, controls and flags.
module tb_mc_control_seq;
   logic clk = 1'b0;
   logic reset = 1'b0;
   int   n_checks = 0;
   int   n_fail = 0;
   logic [3:0] m_flags = 4'b0000;
   logic       m_cx = 1'b0;

   mc_control_seq_if #(.STATE_W(4)) bus();
   mc_control_seq #(.STATE_W(4)) dut (.clk(clk), .reset(reset), .bus(bus));

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout required completion");
      $fatal(1);
   end

   // 0 ADD, 1 SUB, 2 AND, 3 ORR, -1 unsupported command
   function automatic int alu_kind(input logic [31:0] instr);
      logic [3:0] cmd;
      cmd = instr[24:21];
      if (cmd == 4'b0100) return 0;
      if (cmd == 4'b0010) return 1;
      if (cmd == 4'b0000) return 2;
      if (cmd == 4'b1100) return 3;
      return -1;
   endfunction

   function automatic int exp_next(input int s, input logic [31:0] instr);
      logic [1:0] op;
      op = instr[27:26];
      case (s)
         0: return 1;
         1: begin
            if (op == 2'b00) return instr[25] ? 7 : 6;
            if (op == 2'b01) return 2;
            if (op == 2'b10) return 9;
            return 0;
         end
         2: return instr[20] ? 3 : 5;
         3: return 4;
         6, 7: return 8;
         default: return 0;
      endcase
   endfunction

   // {PCWrite,MemWrite,RegWrite,IRWrite,AdrSrc,ALUSrcA,ALUSrcB,ResultSrc,ImmSrc,RegSrc,ALUControl}
   function automatic logic [16:0] exp_ctl(input int s, input logic [31:0] instr, input logic cx);
      logic [1:0] op, srca, srcb, res, aluc;
      logic regw, memw, br, pcs, pcw;
      int k;
      op   = instr[27:26];
      k    = alu_kind(instr);
      regw = (s == 4) || (s == 8 && k >= 0);
      memw = (s == 5);
      br   = (s == 9);
      pcs  = ((instr[15:12] == 4'hF) && regw) || br;
      pcw  = (s == 0) || (pcs && cx);
      srca = (s <= 1) ? 2'b01 : 2'b00;
      srcb = (s <= 1) ? 2'b10 : ((s == 2 || s == 7 || s == 9) ? 2'b01 : 2'b00);
      res  = (s <= 1 || s == 9) ? 2'b10 : ((s == 4) ? 2'b01 : 2'b00);
      aluc = ((s == 6 || s == 7) && k > 0) ? k[1:0] : 2'b00;
      return {pcw, memw & cx, regw & cx, s == 0, (s == 3 || s == 5), srca, srcb, res,
              op, op == 2'b01, op == 2'b10, aluc};
   endfunction

   // Runs one instruction from FETCH back to FETCH, checking every cycle.
   task automatic run_instr(input logic [31:0] instr, input logic cx_dec, input logic cx_late,
                            input logic [3:0] alf, input string tag);
      int s;
      int steps;
      int k;
      string trace;
      logic [16:0] exp;
      logic [16:0] act;
      s = 0;
      steps = 0;
      trace = "";
      k = alu_kind(instr);
      bus.Instr = instr;
      bus.ALUFlags = alf;
      do begin
         bus.CondEx = (s >= 2) ? cx_late : cx_dec;
         #1;
         exp = exp_ctl(s, instr, m_cx);
         act = {bus.PCWrite, bus.MemWrite, bus.RegWrite, bus.IRWrite, bus.AdrSrc, bus.ALUSrcA,
                bus.ALUSrcB, bus.ResultSrc, bus.ImmSrc, bus.RegSrc, bus.ALUControl};
         n_checks++;
         if (bus.State !== s[3:0]) begin
            n_fail++;
            $display("FAIL %s state: got %0d required %0d", tag, bus.State, s);
         end
         n_checks++;
         if (act !== exp) begin
            n_fail++;
            $display("FAIL %s controls in state %0d: got %b required %b", tag, s, act, exp);
         end
         n_checks++;
         if (bus.Flags !== m_flags) begin
            n_fail++;
            $display("FAIL %s flags in state %0d: got %b required %b", tag, s, bus.Flags, m_flags);
         end
         trace = {trace, $sformatf("%0d ", s)};
         @(posedge clk);
         if (s == 1)
            m_cx = cx_dec;
         else if ((s == 6 || s == 7) && m_cx && k >= 0 && instr[20]) begin
            m_flags[3:2] = alf[3:2];
            if (k <= 1) m_flags[1:0] = alf[1:0];
         end
         s = exp_next(s, instr);
         steps++;
         @(negedge clk);
      end while (s != 0 && steps < 8);
      n_checks++;
      if (s != 0) begin
         n_fail++;
         $display("FAIL %s cycle budget: got %0d steps required return to FETCH", tag, steps);
      end
      $display("%s instr=%h cx=%b/%b alu=%b states: %sflags=%b", tag, instr, cx_dec, cx_late,
               alf, trace, bus.Flags);
   endtask

   task automatic test_reset();
      bus.Instr = 32'hE5821004;
      bus.ALUFlags = 4'b1111;
      bus.CondEx = 1'b1;
      reset = 1'b0;
      #2;
      n_checks++;
      if (bus.State !== 4'd0 || bus.Flags !== 4'b0000) begin
         n_fail++;
         $display("FAIL reset state/flags: got %0d/%b required 0/0000", bus.State, bus.Flags);
      end
      repeat (3) @(posedge clk);
      #1;
      n_checks++;
      if ({bus.PCWrite, bus.IRWrite, bus.MemWrite, bus.RegWrite, bus.State} !== {4'b1100, 4'd0}) begin
         n_fail++;
         $display("FAIL reset held outputs: got pcw=%b irw=%b mw=%b rw=%b st=%0d required 1 1 0 0 0",
                  bus.PCWrite, bus.IRWrite, bus.MemWrite, bus.RegWrite, bus.State);
      end
      @(negedge clk);
      reset = 1'b1;
      m_flags = 4'b0000;
      m_cx = 1'b0;
      $display("reset: state=%0d flags=%b", bus.State, bus.Flags);
   endtask

   task automatic test_add();
      run_instr(32'hE0821003, 1'b1, 1'b1, 4'b1111, "add");
      n_checks++;
      if (bus.Flags !== 4'b0000) begin
         n_fail++;
         $display("FAIL add no-S flags: got %b required 0000", bus.Flags);
      end
   endtask

   task automatic test_flags();
      run_instr(32'hE2511001, 1'b1, 1'b1, 4'b0110, "subs");
      n_checks++;
      if (bus.Flags !== 4'b0110) begin
         n_fail++;
         $display("FAIL subs flags: got %b required 0110", bus.Flags);
      end
      run_instr(32'hE2111001, 1'b1, 1'b1, 4'b1001, "ands");
      n_checks++;
      if (bus.Flags !== 4'b1010) begin
         n_fail++;
         $display("FAIL ands flags: got %b required 1010", bus.Flags);
      end
   endtask

   task automatic test_mem();
      run_instr(32'hE5921004, 1'b1, 1'b1, 4'b0000, "ldr");
      run_instr(32'hE5821004, 1'b1, 1'b1, 4'b0000, "str");
      run_instr(32'hE5821004, 1'b0, 1'b0, 4'b0000, "str_nc");
   endtask

   task automatic test_branch();
      run_instr(32'h0A000002, 1'b0, 1'b0, 4'b0000, "beq_nt");
      run_instr(32'h0A000002, 1'b1, 1'b1, 4'b0000, "beq_t");
   endtask

   task automatic test_pc_write();
      run_instr(32'hE082F003, 1'b1, 1'b1, 4'b0000, "add_pc");
      run_instr(32'hE082F003, 1'b1, 1'b0, 4'b0000, "add_pc_latch");
      run_instr(32'hEC000000, 1'b1, 1'b1, 4'b1111, "undef");
   endtask

   task automatic test_reset_midinstr();
      bus.Instr = 32'hE5821004;
      bus.CondEx = 1'b1;
      repeat (3) begin
         @(posedge clk);
         @(negedge clk);
      end
      #1;
      n_checks++;
      if (bus.State !== 4'd5 || bus.MemWrite !== 1'b1) begin
         n_fail++;
         $display("FAIL memwr before reset: got st=%0d mw=%b required 5 1", bus.State, bus.MemWrite);
      end
      #1 reset = 1'b0;
      #1;
      n_checks++;
      if (bus.State !== 4'd0 || bus.MemWrite !== 1'b0 || bus.Flags !== 4'b0000 || bus.PCWrite !== 1'b1) begin
         n_fail++;
         $display("FAIL async reset abort: got st=%0d mw=%b fl=%b pcw=%b required 0 0 0000 1",
                  bus.State, bus.MemWrite, bus.Flags, bus.PCWrite);
      end
      @(negedge clk);
      reset = 1'b1;
      m_flags = 4'b0000;
      m_cx = 1'b0;
      $display("reset_memwr: state=%0d flags=%b", bus.State, bus.Flags);
   endtask

   task automatic test_random();
      logic [31:0] instr;
      logic [3:0]  cmds [4];
      cmds[0] = 4'b0100; cmds[1] = 4'b0010; cmds[2] = 4'b0000; cmds[3] = 4'b1100;
      for (int i = 0; i < 40; i++) begin
         instr = $urandom;
         if ($urandom_range(0, 3) != 0) instr[24:21] = cmds[$urandom_range(0, 3)];
         if ($urandom_range(0, 3) == 0) instr[15:12] = 4'hF;
         run_instr(instr, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                   4'($urandom_range(0, 15)), $sformatf("rnd%0d", i));
      end
   endtask

   initial begin
      bus.Instr = 32'h0;
      bus.ALUFlags = 4'h0;
      bus.CondEx = 1'b0;
      test_reset();
      test_add();
      test_flags();
      test_mem();
      test_branch();
      test_pc_write();
      test_flags();
      test_reset_midinstr();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
